// File: rtl/gpio_tx_queue_if.sv
// gpio_tx_queue_if: core-side push port and link-side message handshake of the GPIO transmit queue.
interface gpio_tx_queue_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          push;
    logic [127:0]  push_message;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          data_ready;
    logic [127:0]  message_out;
    logic          done;
    logic          sent;
    logic          dropped;
    modport master (
        output push, push_message, done,
        input  full, count, overflow, data_ready, message_out, sent, dropped
    );
    modport slave (
        input  push, push_message, done,
        output full, count, overflow, data_ready, message_out, sent, dropped
    );
endinterface

// File: rtl/gpio_tx_queue.sv
// gpio_tx_queue: FIFO of 128-bit messages fed to the GPIO link one at a time, with timeout/retry/drop.
module gpio_tx_queue #(
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input logic            clock,
    input logic            reset,
    gpio_tx_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] retry;
    logic [127:0]  message_out;
    logic          data_ready, sent, dropped, overflow;
    state_t        state;

    logic full, push_ok, expired, last_try, pop;
    // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push.
    assign full     = count == CW'(DEPTH);
    assign push_ok  = bus.push && !full;
    assign expired  = state == SEND && !bus.done && tcnt == TW'(TIMEOUT - 1);
    assign last_try = retry == RW'(MAX_RETRY - 1);
    assign pop      = state == SEND && (bus.done || (expired && last_try));

    always_ff @(posedge clock)
        if (push_ok) mem[wr_ptr] <= bus.push_message;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tcnt        <= '0;
            retry       <= '0;
            message_out <= '0;
            data_ready  <= 1'b0;
            sent        <= 1'b0;
            dropped     <= 1'b0;
            overflow    <= 1'b0;
            state       <= IDLE;
        end else begin
            overflow <= bus.push && full;
            sent     <= state == SEND && bus.done;
            dropped  <= expired && last_try;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
            case (state)
                IDLE: if (count != '0) state <= LOAD;
                LOAD: begin
                    message_out <= mem[rd_ptr];
                    tcnt        <= '0;
                    data_ready  <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    if (bus.done) begin
                        retry      <= '0;
                        data_ready <= 1'b0;
                        state      <= GAP;
                    end else if (expired) begin
                        retry      <= last_try ? '0 : retry + 1'b1;
                        data_ready <= 1'b0;
                        state      <= GAP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP:     state <= count != '0 ? LOAD : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full        = full;
    assign bus.count       = count;
    assign bus.overflow    = overflow;
    assign bus.data_ready  = data_ready;
    assign bus.message_out = message_out;
    assign bus.sent        = sent;
    assign bus.dropped     = dropped;
endmodule

// File: tb/tb_gpio_tx_queue.sv
// tb_gpio_tx_queue: directed checks of queueing, handshake timing, retry/drop and reset for gpio_tx_queue.
module tb_gpio_tx_queue;
    logic clock, reset;
    int   n_cmp, n_err;

    gpio_tx_queue_if #(.DEPTH(4)) bus ();
    gpio_tx_queue #(.DEPTH(4), .TIMEOUT(64), .MAX_RETRY(3)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_dr(output int lat);
        lat = 0;
        while (!bus.data_ready && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic window(output int w);
        w = 0;
        while (bus.data_ready && w < 300) begin
            step();
            w++;
        end
    endtask

    task automatic push_one(input logic [127:0] m);
        bus.push         = 1'b1;
        bus.push_message = m;
        step();
        bus.push = 1'b0;
    endtask

    task automatic ack();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
    endtask

    // One message into an idle empty queue, acknowledged 5 cycles after data_ready rises.
    task automatic single(input logic [127:0] m);
        int lat;
        push_one(m);
        chk("single_count1", bus.count, 1);
        wait_dr(lat);
        chk("single_latency", lat, 2);
        chk("single_msg", bus.message_out, m);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("single_dr_hold", bus.data_ready, 1);
            chk("single_msg_hold", bus.message_out, m);
        end
        ack();
        chk("single_dr_low", bus.data_ready, 0);
        chk("single_sent", bus.sent, 1);
        chk("single_count0", bus.count, 0);
        step();
        chk("single_sent_pulse", bus.sent, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] m [5];
        int lat, w;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.push = 1'b0;
        bus.push_message = '0;
        bus.done = 1'b0;
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_dr", bus.data_ready, 0);
        chk("rst_msg", bus.message_out, 0);
        chk("rst_full", bus.full, 0);
        step();
        step();
        reset = 1'b0;
        step();

        single(128'h1);

        for (int i = 0; i < 5; i++) m[i] = {32'hA000 + i, 96'h0, 8'(i) + 8'h10};
        for (int i = 0; i < 5; i++) push_one(m[i]);
        chk("fill_overflow", bus.overflow, 1);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 4);
        step();
        chk("fill_overflow_pulse", bus.overflow, 0);
        for (int k = 0; k < 4; k++) begin
            wait_dr(lat);
            if (k > 0) chk("fifo_gap", lat, 2);
            chk("fifo_order", bus.message_out, m[k]);
            ack();
            chk("fifo_sent", bus.sent, 1);
        end
        chk("fifo_empty", bus.count, 0);
        for (int i = 0; i < 6; i++) step();
        chk("fifo_no_fifth", bus.data_ready, 0);
        chk("fifo_msg_kept", bus.message_out, m[3]);

        push_one(128'hDEAD);
        for (int a = 0; a < 3; a++) begin
            wait_dr(lat);
            chk("to_gap", lat, 2);
            window(w);
            chk("to_window", w, 64);
            chk("to_dropped", bus.dropped, a == 2);
        end
        chk("to_count", bus.count, 0);
        step();
        chk("to_drop_pulse", bus.dropped, 0);
        for (int i = 0; i < 10; i++) step();
        chk("to_dr_idle", bus.data_ready, 0);

        push_one(128'hA);
        push_one(128'hB);
        wait_dr(lat);
        window(w);
        chk("rt_first_window", w, 64);
        wait_dr(lat);
        chk("rt_msg_a", bus.message_out, 128'hA);
        for (int i = 0; i < 9; i++) step();
        ack();
        chk("rt_sent", bus.sent, 1);
        chk("rt_not_dropped", bus.dropped, 0);
        for (int a = 0; a < 3; a++) begin
            wait_dr(lat);
            chk("rt_msg_b", bus.message_out, 128'hB);
            window(w);
            chk("rt_b_window", w, 64);
            chk("rt_b_dropped", bus.dropped, a == 2);
        end

        for (int i = 0; i < 4; i++) push_one(m[i]);
        wait_dr(lat);
        chk("fp_full", bus.full, 1);
        bus.push = 1'b1;
        bus.push_message = 128'hBAD;
        bus.done = 1'b1;
        step();
        bus.push = 1'b0;
        bus.done = 1'b0;
        chk("fp_overflow", bus.overflow, 1);
        chk("fp_count3", bus.count, 3);
        wait_dr(lat);
        ack();
        chk("fp_count2", bus.count, 2);
        wait_dr(lat);
        chk("fp_msg2", bus.message_out, m[2]);
        bus.push = 1'b1;
        bus.push_message = 128'hC0DE;
        bus.done = 1'b1;
        step();
        bus.push = 1'b0;
        bus.done = 1'b0;
        chk("fp_count_same", bus.count, 2);
        chk("fp_no_overflow", bus.overflow, 0);
        wait_dr(lat);
        chk("fp_msg3", bus.message_out, m[3]);
        ack();
        wait_dr(lat);
        chk("fp_msg_new", bus.message_out, 128'hC0DE);
        ack();
        chk("fp_drained", bus.count, 0);

        for (int i = 0; i < 3; i++) push_one(m[i]);
        wait_dr(lat);
        for (int i = 0; i < 20; i++) step();
        reset = 1'b1;
        #1;
        chk("mr_dr", bus.data_ready, 0);
        chk("mr_count", bus.count, 0);
        chk("mr_msg", bus.message_out, 0);
        step();
        step();
        reset = 1'b0;
        bus.done = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.done = 1'b0;
        chk("mr_done_ignored_dr", bus.data_ready, 0);
        chk("mr_done_ignored_sent", bus.sent, 0);
        chk("mr_count_after", bus.count, 0);
        single(128'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
